// File: rtl/pulse_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_arbiter_if
// Purpose  : Request/grant and burst-generator signals of the pulse burst
//            arbiter, bundled with master (requester side) and slave
//            (arbiter side) views.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_burst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     pulser_start;
  logic [CNT_W-1:0]         pulser_num;
  logic                     pulser_last;
  logic                     busy;

  modport slave (
    input  req, req_count, pulser_last,
    output gnt, done, pulser_start, pulser_num, busy
  );

  modport master (
    output req, req_count, pulser_last,
    input  gnt, done, pulser_start, pulser_num, busy
  );
endinterface
`default_nettype wire

// File: rtl/pulse_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_arbiter
// Purpose  : Round-robin sharing of one pulse burst generator between
//            NUM_REQ requesters, with a per-requester done strobe and an
//            enforced idle gap between consecutive bursts.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  pulse_burst_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LAUNCH = 2'd1;
  localparam logic [1:0] c_ACTIVE = 2'd2;
  localparam logic [1:0] c_GAP    = 2'd3;

  // Where a finished burst goes: straight back to IDLE when no gap is wanted.
  localparam logic [1:0] c_POST_DONE = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;
  localparam logic [3:0] c_GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_start;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [3:0]         r_gap;
  logic               r_busy;

  logic [1:0]         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               w_start_nxt;
  logic [CNT_W-1:0]   w_num_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [3:0]         w_gap_nxt;

  logic [CNT_W-1:0]   w_cnt_arr [NUM_REQ];
  logic [PTR_W:0]     w_sum;
  logic [PTR_W-1:0]   w_idx;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_win_inc;
  logic [NUM_REQ-1:0] w_win_oh;

  // Split the flat count bus into one count per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_cnt_arr[gi] = bus.req_count[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // Round-robin pick: first set request scanning upward from the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_inc = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_win_oh  = NUM_REQ'(1) << w_win;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_start_nxt = 1'b0;
    w_num_nxt   = r_num;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gap_nxt   = r_gap;
    case (r_state)
      c_IDLE: begin
        // Generator last flag is deliberately ignored here (may be draining after reset).
        if (w_found) begin
          w_gnt_nxt   = w_win_oh;
          w_cnt_nxt   = w_cnt_arr[w_win];
          w_ptr_nxt   = w_win_inc;
          w_state_nxt = c_LAUNCH;
        end
      end
      c_LAUNCH: begin
        if (r_cnt != '0) begin
          w_start_nxt = 1'b1;
          w_num_nxt   = r_cnt;
          w_state_nxt = c_ACTIVE;
        end else begin
          // Zero-length burst: never touch the generator, complete immediately.
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_gap_nxt   = '0;
          w_state_nxt = c_POST_DONE;
        end
      end
      c_ACTIVE: begin
        if (bus.pulser_last) begin
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_gap_nxt   = '0;
          w_state_nxt = c_POST_DONE;
        end
      end
      default: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = c_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
    endcase
  end

  // State and output registers with asynchronous reset to an idle, pointer-at-0 arbiter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_start <= w_start_nxt;
      r_num   <= w_num_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= (w_state_nxt != c_IDLE);
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.done         = r_done;
  assign bus.pulser_start = r_start;
  assign bus.pulser_num   = r_num;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_burst_arbiter
// Purpose  : Self-checking bench for pulse_burst_arbiter: directed scenarios
//            plus randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  pulse_burst_arbiter_if #(.NUM_REQ(N), .CNT_W(CW)) bus1 ();
  pulse_burst_arbiter_if #(.NUM_REQ(N), .CNT_W(CW)) bus3 ();

  pulse_burst_arbiter #(.NUM_REQ(N), .CNT_W(CW), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  pulse_burst_arbiter #(.NUM_REQ(N), .CNT_W(CW), .GAP_CYCLES(3)) dut_g3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Burst generator models: no reset, N pulses after a start, last flag on the final one.
  logic [CW-1:0] gen1_rem = '0;
  logic [CW-1:0] gen3_rem = '0;

  always @(posedge clk) begin
    if (bus1.pulser_start) gen1_rem <= bus1.pulser_num;
    else if (gen1_rem != 0) gen1_rem <= gen1_rem - 1'b1;
  end

  always @(posedge clk) begin
    if (bus3.pulser_start) gen3_rem <= bus3.pulser_num;
    else if (gen3_rem != 0) gen3_rem <= gen3_rem - 1'b1;
  end

  assign bus1.pulser_last = (gen1_rem == 1);
  assign bus3.pulser_last = (gen3_rem == 1);

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus1.req = '0;
    bus3.req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus1.gnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done1(output bit ok, output bit last_prev);
    ok = 1'b0;
    last_prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      last_prev = bus1.pulser_last;
      tick();
      if (bus1.done != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.req = '0; bus1.req_count = '0;
    bus3.req = '0; bus3.req_count = '0;
    repeat (2) tick();
    checks++;
    if ({bus1.gnt, bus1.done, bus1.pulser_start, bus1.pulser_num, bus1.busy} !== '0) begin
      errors++;
      $display("FAIL reset_in_bus1: got gnt=%b done=%b start=%b num=%0d busy=%b, expected all 0",
               bus1.gnt, bus1.done, bus1.pulser_start, bus1.pulser_num, bus1.busy);
    end
    checks++;
    if ({bus3.gnt, bus3.done, bus3.pulser_start, bus3.pulser_num, bus3.busy} !== '0) begin
      errors++;
      $display("FAIL reset_in_bus3: got gnt=%b done=%b start=%b num=%0d busy=%b, expected all 0",
               bus3.gnt, bus3.done, bus3.pulser_start, bus3.pulser_num, bus3.busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus1.gnt, bus1.done, bus1.pulser_start, bus1.busy} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got gnt=%b done=%b start=%b busy=%b, expected all 0",
               bus1.gnt, bus1.done, bus1.pulser_start, bus1.busy);
    end
  endtask

  task automatic test_single();
    bit ok, lp;
    bus1.req = 4'b0001;
    bus1.req_count = {4'd0, 4'd0, 4'd0, 4'd3};
    tick();
    checks++;
    if (bus1.gnt !== 4'b0001 || bus1.pulser_start !== 1'b0 || bus1.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b start=%b busy=%b, expected 0001 0 1",
               bus1.gnt, bus1.pulser_start, bus1.busy);
    end
    bus1.req = '0;
    tick();
    checks++;
    if (bus1.pulser_start !== 1'b1 || bus1.pulser_num !== 4'd3 || bus1.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_launch: got start=%b num=%0d gnt=%b, expected 1 3 0001",
               bus1.pulser_start, bus1.pulser_num, bus1.gnt);
    end
    wait_done1(ok, lp);
    checks++;
    if (!ok || bus1.done !== 4'b0001 || !lp || bus1.gnt !== 4'b0000 || bus1.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got ok=%b done=%b last_prev=%b gnt=%b busy=%b, expected 1 0001 1 0000 1",
               ok, bus1.done, lp, bus1.gnt, bus1.busy);
    end
    tick();
    checks++;
    if (bus1.done !== 4'b0000 || bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after_gap: got done=%b busy=%b, expected 0000 0", bus1.done, bus1.busy);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int done_cyc = 0;
    bit ok, lp;
    logic [N-1:0] g;
    do_reset();
    bus1.req_count = {4'd4, 4'd3, 4'd2, 4'd1};
    bus1.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt1(ok);
      checks++;
      if (!ok || bus1.gnt !== 4'(1 << order[t])) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got ok=%b gnt=%b, expected %b", t, ok, bus1.gnt, 4'(1 << order[t]));
      end
      if (t > 0) begin
        checks++;
        if (cyc - done_cyc != 2) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles done->gnt, expected 2", t, cyc - done_cyc);
        end
      end
      g = bus1.gnt;
      tick();
      checks++;
      if (bus1.pulser_start !== 1'b1 || bus1.pulser_num !== CW'(order[t] + 1)) begin
        errors++;
        $display("FAIL rr_launch[%0d]: got start=%b num=%0d, expected 1 %0d",
                 t, bus1.pulser_start, bus1.pulser_num, order[t] + 1);
      end
      if (t == 4) bus1.req = '0;
      wait_done1(ok, lp);
      checks++;
      if (!ok || bus1.done !== g || !lp || bus1.gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_done[%0d]: got ok=%b done=%b last_prev=%b gnt=%b, expected 1 %b 1 0000",
                 t, ok, bus1.done, lp, bus1.gnt, g);
      end
      done_cyc = cyc;
    end
    repeat (3) tick();
  endtask

  task automatic test_zero_count();
    bit bad = 1'b0;
    bus1.req = 4'b0100;
    bus1.req_count = {4'd7, 4'd0, 4'd7, 4'd7};
    tick();
    checks++;
    if (bus1.gnt !== 4'b0100 || bus1.pulser_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_grant: got gnt=%b start=%b, expected 0100 0", bus1.gnt, bus1.pulser_start);
    end
    bus1.req = '0;
    tick();
    checks++;
    if (bus1.done !== 4'b0100 || bus1.gnt !== 4'b0000 || bus1.pulser_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b gnt=%b start=%b, expected 0100 0000 0",
               bus1.done, bus1.gnt, bus1.pulser_start);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus1.pulser_start !== 1'b0 || bus1.done !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zero_quiet: got start or done activity after zero burst, expected none");
    end
  endtask

  task automatic test_midburst();
    bit ok = 1'b0, lp = 1'b0, bad_num = 1'b0;
    bus1.req = 4'b0001;
    bus1.req_count = {4'd7, 4'd0, 4'd7, 4'd5};
    tick();
    checks++;
    if (bus1.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_grant: got gnt=%b, expected 0001", bus1.gnt);
    end
    tick();
    checks++;
    if (bus1.pulser_start !== 1'b1 || bus1.pulser_num !== 4'd5) begin
      errors++;
      $display("FAIL mid_launch: got start=%b num=%0d, expected 1 5", bus1.pulser_start, bus1.pulser_num);
    end
    bus1.req = '0;
    bus1.req_count = {4'd7, 4'd0, 4'd7, 4'd9};
    for (int i = 0; i < 40; i++) begin
      lp = bus1.pulser_last;
      tick();
      if (bus1.pulser_num !== 4'd5) bad_num = 1'b1;
      if (bus1.done != 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (bad_num) begin
      errors++;
      $display("FAIL mid_num_hold: got pulser_num change during burst, expected constant 5");
    end
    checks++;
    if (!ok || !lp || bus1.done !== 4'b0001) begin
      errors++;
      $display("FAIL mid_done: got ok=%b last_prev=%b done=%b, expected 1 1 0001", ok, lp, bus1.done);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_active();
    bit bad = 1'b0, ok, lp;
    bus1.req = 4'b0010;
    bus1.req_count = {4'd7, 4'd0, 4'd6, 4'd9};
    tick();
    checks++;
    if (bus1.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rst_act_grant: got gnt=%b, expected 0010", bus1.gnt);
    end
    bus1.req = '0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus1.gnt, bus1.done, bus1.pulser_start, bus1.pulser_num, bus1.busy} !== '0) begin
      errors++;
      $display("FAIL rst_act_async: got gnt=%b done=%b start=%b num=%0d busy=%b, expected all 0",
               bus1.gnt, bus1.done, bus1.pulser_start, bus1.pulser_num, bus1.busy);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus1.done !== 4'b0000 || bus1.gnt !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_act_no_done: got done/gnt activity while generator drained, expected none");
    end
    bus1.req = 4'b0111;
    bus1.req_count = {4'd0, 4'd3, 4'd3, 4'd2};
    tick();
    checks++;
    if (bus1.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_act_ptr: got gnt=%b, expected 0001", bus1.gnt);
    end
    bus1.req = '0;
    wait_done1(ok, lp);
    checks++;
    if (!ok || bus1.done !== 4'b0001) begin
      errors++;
      $display("FAIL rst_act_done: got ok=%b done=%b, expected 1 0001", ok, bus1.done);
    end
    repeat (2) tick();
  endtask

  task automatic test_gap();
    bit ok = 1'b0;
    int d;
    bus3.req = 4'b0011;
    bus3.req_count = {4'd0, 4'd0, 4'd3, 4'd2};
    tick();
    checks++;
    if (bus3.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL gap_grant0: got gnt=%b, expected 0001", bus3.gnt);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus3.done != 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus3.done !== 4'b0001) begin
      errors++;
      $display("FAIL gap_done0: got ok=%b done=%b, expected 1 0001", ok, bus3.done);
    end
    d = cyc;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus3.gnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus3.gnt !== 4'b0010 || cyc - d - 1 != 3) begin
      errors++;
      $display("FAIL gap_idle_cycles: got ok=%b gnt=%b idle=%0d, expected 1 0010 3", ok, bus3.gnt, cyc - d - 1);
    end
    bus3.req = '0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus3.done != 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bus3.done !== 4'b0010) begin
      errors++;
      $display("FAIL gap_done1: got ok=%b done=%b, expected 1 0010", ok, bus3.done);
    end
    repeat (5) tick();
  endtask

  task automatic drive_rand1(output logic [N-1:0] r, output logic [N*CW-1:0] rc);
    r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++)
      rc[i*CW +: CW] = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 6));
    bus1.req = r;
    bus1.req_count = rc;
  endtask

  task automatic test_random();
    logic [N-1:0]    sreq, dreq;
    logic [N*CW-1:0] scnt, dcnt;
    logic [N-1:0]    eoh;
    logic [CW-1:0]   ecnt;
    int  mptr = 0, w, last_done, grants = 0;
    bit  exp_grant, ok, lp, bad;
    do_reset();
    last_done = cyc - 2;
    for (int it = 0; it < 4000 && grants < 40; it++) begin
      drive_rand1(sreq, scnt);
      tick();
      exp_grant = (cyc >= last_done + 2) && (sreq != 0);
      checks++;
      if ((bus1.gnt != 0) !== exp_grant) begin
        errors++;
        $display("FAIL rnd_grant_timing: got gnt=%b, expected grant=%b (req=%b cyc=%0d)",
                 bus1.gnt, exp_grant, sreq, cyc);
      end
      checks++;
      if (bus1.done !== '0 || bus1.pulser_start !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle_quiet: got done=%b start=%b, expected 0000 0", bus1.done, bus1.pulser_start);
      end
      if (bus1.gnt != 0) begin
        w = 0;
        for (int k = 0; k < N; k++) begin
          int idx = (mptr + k) % N;
          if (sreq[idx]) begin
            w = idx;
            break;
          end
        end
        eoh  = N'(1 << w);
        ecnt = scnt[w*CW +: CW];
        mptr = (w + 1) % N;
        checks++;
        if (bus1.gnt !== eoh) begin
          errors++;
          $display("FAIL rnd_winner: got gnt=%b, expected %b (req=%b)", bus1.gnt, eoh, sreq);
        end
        drive_rand1(dreq, dcnt);
        tick();
        if (ecnt == 0) begin
          checks++;
          if (bus1.done !== eoh || bus1.gnt !== '0 || bus1.pulser_start !== 1'b0) begin
            errors++;
            $display("FAIL rnd_zero_done: got done=%b gnt=%b start=%b, expected %b 0000 0",
                     bus1.done, bus1.gnt, bus1.pulser_start, eoh);
          end
        end else begin
          checks++;
          if (bus1.pulser_start !== 1'b1 || bus1.pulser_num !== ecnt || bus1.gnt !== eoh) begin
            errors++;
            $display("FAIL rnd_launch: got start=%b num=%0d gnt=%b, expected 1 %0d %b",
                     bus1.pulser_start, bus1.pulser_num, bus1.gnt, ecnt, eoh);
          end
          ok = 1'b0; lp = 1'b0; bad = 1'b0;
          for (int i = 0; i < 30; i++) begin
            lp = bus1.pulser_last;
            drive_rand1(dreq, dcnt);
            tick();
            if (bus1.done != 0) begin
              ok = 1'b1;
              break;
            end
            if (bus1.gnt !== eoh || bus1.pulser_start !== 1'b0 || bus1.pulser_num !== ecnt) bad = 1'b1;
          end
          checks++;
          if (!ok || !lp || bad || bus1.done !== eoh || bus1.gnt !== '0) begin
            errors++;
            $display("FAIL rnd_burst: got ok=%b last_prev=%b bad=%b done=%b gnt=%b, expected 1 1 0 %b 0000",
                     ok, lp, bad, bus1.done, bus1.gnt, eoh);
          end
        end
        last_done = cyc;
        grants++;
      end
    end
    checks++;
    if (grants < 40) begin
      errors++;
      $display("FAIL rnd_progress: got %0d grants, expected 40", grants);
    end
    bus1.req = '0;
    repeat (3) tick();
  endtask

  initial begin
    bus1.req = '0; bus1.req_count = '0;
    bus3.req = '0; bus3.req_count = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_midburst();
    test_reset_active();
    test_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
